// File: rtl/pll_loop_nco_pkg.sv
// Shared definitions for the PLL back end: state encoding, default widths,
// nominal FCW and the saturating adder shared with the phase detector.
package pll_pkg;

  localparam int unsigned PLL_ERR_W   = 12;
  localparam int unsigned PLL_PHASE_W = 24;
  localparam int unsigned PLL_INT_W   = 20;

  localparam logic [PLL_PHASE_W-1:0] PLL_FCW_NOM = 24'h100000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } pll_state_t;

  // Signed add clamped to a w-bit two's complement range (w <= 32).
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi[31:0];
    end else if (sum < lo) begin
      return lo[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/pll_loop_nco_nco.sv
// Phase-accumulator NCO: advances by the FCW every clock and exposes the
// recovered clock, a carry-out wrap strobe and the truncated phase.
module pll_nco
  import pll_pkg::*;
#(
  parameter int unsigned PHASE_W = PLL_PHASE_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PHASE_W-1:0] fcw,
  output logic [11:0]        phase_out,
  output logic               nco_clk_out,
  output logic               nco_wrap
);

  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W:0]   acc_sum;

  assign acc_sum = {1'b0, phase_acc} + {1'b0, fcw};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_acc <= '0;
      nco_wrap  <= 1'b0;
    end else begin
      phase_acc <= acc_sum[PHASE_W-1:0];
      nco_wrap  <= acc_sum[PHASE_W];
    end
  end

  assign phase_out   = phase_acc[PHASE_W-1 -: 12];
  assign nco_clk_out = phase_acc[PHASE_W-1];

endmodule

// File: rtl/pll_loop_nco.sv
// Digital PLL back end: PI loop filter producing the FCW, NCO, and a lock
// detector compiled in only when PLL_LOCK_DETECT_EN is defined.
module pll_loop_nco
  import pll_pkg::*;
#(
  parameter int unsigned        ERR_W       = PLL_ERR_W,
  parameter int unsigned        PHASE_W     = PLL_PHASE_W,
  parameter int unsigned        INT_W       = PLL_INT_W,
  parameter int unsigned        KP_SHIFT    = 2,
  parameter int unsigned        KI_SHIFT    = 8,
  parameter logic [PHASE_W-1:0] FCW_NOM     = PLL_FCW_NOM,
  parameter int unsigned        LOCK_THRESH = 32,
  parameter int unsigned        LOCK_COUNT  = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    err_valid,
  input  logic                    enable,
  output logic [PHASE_W-1:0]      fcw_out,
  output logic [11:0]             phase_out,
  output logic                    nco_clk_out,
  output logic                    nco_wrap,
  output logic                    integ_sat,
  output logic                    locked
);

  localparam logic signed [INT_W-1:0]   INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0]   INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [PHASE_W+1:0] NOM_EXT = {2'b00, FCW_NOM};
  localparam logic signed [PHASE_W+1:0] FCW_MAX = {3'b000, {(PHASE_W-1){1'b1}}};

  pll_state_t               state;
  logic signed [INT_W-1:0]  integ;
  logic signed [ERR_W-1:0]  prop;
  logic signed [INT_W-1:0]  integ_nxt;
  logic signed [PHASE_W+1:0] fcw_sum;
  logic [PHASE_W-1:0]       fcw_clamp;

  always_comb begin
    integ_nxt = INT_W'(sat_add(32'(integ), 32'(err_in), INT_W));
  end

  // Sum is two bits wider than the FCW so both negative and above-Nyquist
  // results are visible before the clamp.
  always_comb begin
    fcw_sum   = NOM_EXT + (PHASE_W+2)'(prop) + (PHASE_W+2)'(integ >>> KI_SHIFT);
    fcw_clamp = fcw_sum[PHASE_W-1:0];
    if (fcw_sum < 0) begin
      fcw_clamp = '0;
    end else if (fcw_sum > FCW_MAX) begin
      fcw_clamp = FCW_MAX[PHASE_W-1:0];
    end
  end

  assign integ_sat = (integ == INT_MAX) || (integ == INT_MIN);

`ifdef PLL_LOCK_DETECT_EN
  localparam int unsigned        CNT_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(LOCK_COUNT);
  localparam logic [ERR_W:0]     THR_LO  = (ERR_W+1)'(LOCK_THRESH);
  localparam logic [ERR_W:0]     THR_HI  = (ERR_W+1)'(2 * LOCK_THRESH);

  logic signed [ERR_W:0] err_ext;
  logic [ERR_W:0]        err_abs;
  logic [CNT_W-1:0]      lock_cnt;
  logic [CNT_W-1:0]      lock_cnt_nxt;

  // One extra bit keeps |-2^(ERR_W-1)| representable.
  assign err_ext = {err_in[ERR_W-1], err_in};
  assign err_abs = err_in[ERR_W-1] ? (ERR_W+1)'(-err_ext) : (ERR_W+1)'(err_ext);

  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (err_abs > THR_LO) begin
      lock_cnt_nxt = '0;
    end else if (lock_cnt != CNT_MAX) begin
      lock_cnt_nxt = lock_cnt + CNT_W'(1);
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      integ   <= '0;
      prop    <= '0;
      fcw_out <= FCW_NOM;
`ifdef PLL_LOCK_DETECT_EN
      lock_cnt <= '0;
      locked   <= 1'b0;
`endif
    end else begin
      fcw_out <= fcw_clamp;
      if (!enable) begin
        state <= IDLE;
        integ <= '0;
        prop  <= '0;
`ifdef PLL_LOCK_DETECT_EN
        lock_cnt <= '0;
        locked   <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= ACQUIRE;
            integ <= '0;
            prop  <= '0;
`ifdef PLL_LOCK_DETECT_EN
            lock_cnt <= '0;
`endif
          end
          default: begin
            if (err_valid) begin
              prop  <= err_in >>> KP_SHIFT;
              integ <= integ_nxt;
`ifdef PLL_LOCK_DETECT_EN
              lock_cnt <= lock_cnt_nxt;
              if (state == ACQUIRE && lock_cnt_nxt == CNT_MAX) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else if (state == LOCKED && err_abs > THR_HI) begin
                state  <= ACQUIRE;
                locked <= 1'b0;
              end
`endif
            end
          end
        endcase
      end
    end
  end

  pll_nco #(
    .PHASE_W(PHASE_W)
  ) u_nco (
    .clock      (clock),
    .reset_n    (reset_n),
    .fcw        (fcw_out),
    .phase_out  (phase_out),
    .nco_clk_out(nco_clk_out),
    .nco_wrap   (nco_wrap)
  );

endmodule

// File: tb/tb_pll_loop_nco.sv
// Directed bench for pll_loop_nco; expectations are queued with a due edge
// when stimulus is applied and compared on the following falling edges.
`timescale 1ns/1ps
module tb_pll_loop_nco;

  localparam logic [23:0] NOM = 24'h100000;

  logic               clock     = 1'b0;
  logic               reset_n   = 1'b0;
  logic signed [11:0] err_in    = '0;
  logic               err_valid = 1'b0;
  logic               enable    = 1'b0;
  logic [23:0]        fcw_out;
  logic [11:0]        phase_out;
  logic               nco_clk_out;
  logic               nco_wrap;
  logic               integ_sat;
  logic               locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {S_FCW, S_PHASE, S_CLK, S_WRAP, S_SAT, S_LOCK, S_INTEG, S_PROP} sel_t;
  typedef struct {
    int          due;
    sel_t        sel;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  logic [23:0] m_ph;
  logic [23:0] m_fcw;
  int          m_integ;
  int          m_prop;

  pll_loop_nco #(
    .ERR_W      (12),
    .PHASE_W    (24),
    .INT_W      (20),
    .KP_SHIFT   (2),
    .KI_SHIFT   (8),
    .FCW_NOM    (24'h100000),
    .LOCK_THRESH(32),
    .LOCK_COUNT (64)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .err_in     (err_in),
    .err_valid  (err_valid),
    .enable     (enable),
    .fcw_out    (fcw_out),
    .phase_out  (phase_out),
    .nco_clk_out(nco_clk_out),
    .nco_wrap   (nco_wrap),
    .integ_sat  (integ_sat),
    .locked     (locked)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] observe(sel_t s);
    case (s)
      S_FCW:   return 32'(fcw_out);
      S_PHASE: return 32'(phase_out);
      S_CLK:   return 32'(nco_clk_out);
      S_WRAP:  return 32'(nco_wrap);
      S_SAT:   return 32'(integ_sat);
      S_LOCK:  return 32'(locked);
      S_INTEG: return 32'(dut.integ);
      S_PROP:  return 32'(dut.prop);
      default: return '0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(int n, sel_t s, logic [31:0] v, string tag);
    sb_t e;
    e.due = cyc + n;
    e.sel = s;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, observe(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    // Reset values and free-running NCO
    tick();
    tick();
    check("rst_fcw", observe(S_FCW), 32'h100000);
    check("rst_phase", observe(S_PHASE), 32'd0);
    check("rst_clk", observe(S_CLK), 32'd0);
    check("rst_wrap", observe(S_WRAP), 32'd0);
    check("rst_sat", observe(S_SAT), 32'd0);
    check("rst_locked", observe(S_LOCK), 32'd0);
    check("rst_integ", observe(S_INTEG), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      expect_at(k, S_WRAP, 32'(k % 16 == 0), "freerun_wrap");
      expect_at(k, S_CLK, 32'((k % 16) >= 8), "freerun_clk");
      expect_at(k, S_PHASE, 32'((k * 256) % 4096), "freerun_phase");
    end
    repeat (33) tick();

    // Step response with constant +256
    enable = 1'b1;
    tick();
    err_in    = 12'sd256;
    err_valid = 1'b1;
    expect_at(1, S_PROP, 32'd64, "step_prop");
    expect_at(1, S_FCW, 32'(NOM), "step_fcw_lat");
    for (int j = 1; j <= 8; j++) begin
      expect_at(j, S_INTEG, 32'(256 * j), "step_integ");
      if (j >= 2) expect_at(j, S_FCW, 32'h100040 + 32'(j - 1), "step_fcw");
    end
    repeat (8) tick();
    enable = 1'b0;
    expect_at(1, S_INTEG, 32'd0, "dis_integ");
    expect_at(1, S_PROP, 32'd0, "dis_prop");
    expect_at(2, S_FCW, 32'(NOM), "dis_fcw");
    repeat (3) tick();

    // Integrator saturation and recovery
    enable    = 1'b1;
    err_valid = 1'b0;
    tick();
    err_in    = 12'sd2047;
    err_valid = 1'b1;
    expect_at(256, S_INTEG, 32'd524032, "sat_integ_256");
    expect_at(256, S_SAT, 32'd0, "sat_flag_256");
    expect_at(257, S_INTEG, 32'd524287, "sat_integ_257");
    expect_at(257, S_SAT, 32'd1, "sat_flag_257");
    expect_at(258, S_INTEG, 32'd524287, "sat_integ_258");
    expect_at(259, S_INTEG, 32'd522240, "sat_recover");
    expect_at(259, S_SAT, 32'd0, "sat_flag_clear");
    expect_at(259, S_PROP, 32'hFFFF_FE00, "prop_neg_shift");
    expect_at(259, S_FCW, 32'h1009FE, "sat_fcw");
    expect_at(260, S_INTEG, 32'd522240, "gap_hold_1");
    expect_at(261, S_INTEG, 32'd522240, "gap_hold_2");
    repeat (258) tick();
    err_in = -12'sd2047;
    tick();
    err_valid = 1'b0;
    repeat (3) tick();
    enable = 1'b0;
    repeat (2) tick();

`ifdef PLL_LOCK_DETECT_EN
    // Lock entry, hysteresis and |err| at the negative limit
    enable    = 1'b1;
    tick();
    err_in    = 12'sd10;
    err_valid = 1'b1;
    expect_at(63, S_LOCK, 32'd0, "lock_before");
    expect_at(64, S_LOCK, 32'd1, "lock_rise");
    repeat (64) tick();
    err_in = 12'sd40;
    expect_at(1, S_LOCK, 32'd1, "lock_hold_40");
    tick();
    err_in = 12'sd65;
    expect_at(1, S_LOCK, 32'd0, "lock_drop_65");
    tick();
    err_in = 12'sd10;
    repeat (63) tick();
    err_in = -12'sd2048;
    expect_at(1, S_LOCK, 32'd0, "lock_abs_min");
    tick();
    err_in = 12'sd10;
    expect_at(1, S_LOCK, 32'd0, "lock_after_min");
    expect_at(64, S_LOCK, 32'd1, "relock");
    repeat (64) tick();
    enable = 1'b0;
    expect_at(1, S_LOCK, 32'd0, "lock_enable_drop");
    repeat (2) tick();
`else
    enable    = 1'b1;
    tick();
    err_in    = 12'sd0;
    err_valid = 1'b1;
    expect_at(70, S_LOCK, 32'd0, "nolock_tied");
    repeat (70) tick();
    enable = 1'b0;
    repeat (2) tick();
`endif

    // Valid gaps from a clean reset: integ steps on valid edges only
    reset_n = 1'b0;
    tick();
    reset_n   = 1'b1;
    enable    = 1'b1;
    err_valid = 1'b0;
    err_in    = 12'sd256;
    tick();
    m_ph    = NOM;
    m_fcw   = NOM;
    m_integ = 0;
    m_prop  = 0;
    for (int i = 0; i < 12; i++) begin
      err_valid = (i % 2 == 0);
      m_ph  = m_ph + m_fcw;
      m_fcw = NOM + 24'(m_prop) + 24'(m_integ >>> 8);
      if (err_valid) begin
        m_integ = m_integ + 256;
        m_prop  = 64;
      end
      expect_at(1, S_INTEG, 32'(m_integ), "gap_integ");
      expect_at(1, S_FCW, 32'(m_fcw), "gap_fcw");
      expect_at(1, S_PHASE, 32'(m_ph[23:12]), "gap_phase");
      tick();
    end
    err_valid = 1'b0;
    enable    = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a locked run
    enable = 1'b1;
    tick();
    err_in    = 12'sd10;
    err_valid = 1'b1;
    repeat (64) tick();
    check("pre_rst_integ", observe(S_INTEG), 32'd640);
`ifdef PLL_LOCK_DETECT_EN
    check("pre_rst_locked", observe(S_LOCK), 32'd1);
`endif
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_fcw", observe(S_FCW), 32'h100000);
    check("async_phase", observe(S_PHASE), 32'd0);
    check("async_clk", observe(S_CLK), 32'd0);
    check("async_wrap", observe(S_WRAP), 32'd0);
    check("async_sat", observe(S_SAT), 32'd0);
    check("async_locked", observe(S_LOCK), 32'd0);
    check("async_integ", observe(S_INTEG), 32'd0);
    check("async_prop", observe(S_PROP), 32'd0);
    enable    = 1'b0;
    err_valid = 1'b0;
    repeat (3) tick();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_loop_nco.md
# pll_loop_nco

Digital PLL back end: consumes the 12-bit signed, moving-average-filtered phase error from the loop FIR and closes the loop. A proportional-integral loop filter computes a frequency control word (FCW), and a phase-accumulator NCO advances by it every clock. The NCO drives the recovered clock, a wrap strobe and a truncated phase back to the phase detector. An optional lock detector flags steady-state tracking.

## Interface
- ERR_W, 12: error input width (two's complement)
- PHASE_W, 24: phase accumulator / FCW width
- INT_W, 20: integrator width (signed)
- KP_SHIFT, 2: proportional gain = 2^-KP_SHIFT
- KI_SHIFT, 8: integral gain = 2^-KI_SHIFT
- FCW_NOM, 24'h100000: free-running FCW (f_clock/16)
- LOCK_THRESH, 32: lock-entry |error| limit
- LOCK_COUNT, 64: consecutive in-limit samples needed to declare lock
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- err_in  in  ERR_W  signed phase error
- err_valid  in  1  err_in is sampled when high (tie high behind the FIR)
- enable  in  1  loop closed when high, free-running when low
- fcw_out  out  PHASE_W  current FCW (unsigned)
- phase_out  out  12  phase_acc[PHASE_W-1 -: 12]
- nco_clk_out  out  1  phase_acc MSB
- nco_wrap  out  1  one-cycle pulse on accumulator carry-out
- integ_sat  out  1  integrator is at either rail
- locked  out  1  lock indication

## Operation
- Reset values: integ=0, prop=0, fcw_out=FCW_NOM, phase_acc=0, nco_wrap=0, integ_sat=0, locked=0, state=IDLE, lock counter=0.
- States: IDLE, ACQUIRE, LOCKED. Reset goes to IDLE. IDLE->ACQUIRE when enable=1. Any state->IDLE when enable=0. ACQUIRE->LOCKED when the counter reaches LOCK_COUNT. LOCKED->ACQUIRE when |err|>2*LOCK_THRESH on a valid sample.
- IDLE: integ, prop and counter cleared; fcw_out=FCW_NOM; NCO keeps running.
- Stage 1, on a valid sample with state≠IDLE:
  - prop <= err>>>KP_SHIFT (arithmetic shift).
  - integ <= sat_INT_W(integ + sext(err)), saturating at -2^(INT_W-1) and 2^(INT_W-1)-1.
  - integ_sat = integ at either rail.
  - With no valid sample, integ, prop and counter hold.
- Stage 2: fcw_out <= FCW_NOM + sext(prop) + (integ>>>KI_SHIFT). The sum is computed at PHASE_W+2 bits and clamped to [0, 2^(PHASE_W-1)-1] (non-negative, below Nyquist).
- Stage 3, every clock regardless of err_valid: {carry, phase_acc} <= phase_acc + fcw_out; nco_wrap <= carry. Wrap-around is modulo 2^PHASE_W.
- |err| is computed at ERR_W+1 bits; err=-2048 gives 2048, with no overflow.
- Lock counter: increments on each valid sample with |err|<=LOCK_THRESH, resets to 0 on a valid sample above it, and saturates at LOCK_COUNT.

## Timing
- Valid err at edge 0 -> prop/integ at edge 1 -> fcw_out at edge 2 -> phase_acc steps by the new FCW at edge 3.
- locked rises on the edge after the LOCK_COUNT-th in-limit sample. It falls on the edge after the offending sample, and on the edge after enable drops.
- enable=0 clears stage 1 at the next edge; fcw_out returns to FCW_NOM one edge later.
- reset_n low forces all registers to their reset values immediately, independent of clock. Release is sampled synchronously.

## Configuration
- PLL_LOCK_DETECT_EN defined: LOCKED state, lock counter and hysteresis compiled in; locked output behaves as specified.
- PLL_LOCK_DETECT_EN undefined: states are IDLE/ACQUIRE only, no counter logic, locked tied to 0. The loop filter is unchanged.

## Structure
- Shared package pll_pkg holds:
  - state enum {IDLE, ACQUIRE, LOCKED}
  - default widths (ERR_W, PHASE_W, INT_W)
  - FCW_NOM
  - a saturating-add function, also used by the phase detector
- One sub-module: pll_nco, containing the phase accumulator, carry/wrap, nco_clk_out and phase_out, fed by fcw_out. The loop filter and FSM live in the top module.

## Test plan
- Reset and free-run: hold reset_n low, enable=0 -> fcw_out=0x100000, outputs 0. After release, nco_wrap pulses every 16 clocks (first at clock 16) and nco_clk_out has period 16 at 50% duty.
- Step response: enable=1, err_in=+256 constant -> prop=64, integ=256 at edge 1; fcw_out=0x100041 at edge 2, then 0x100042 one edge later.
- Integrator saturation: err_in=+2047 continuously -> integ=524287 and integ_sat=1 after sample 257. One sample of -2047 -> integ=522240, integ_sat=0.
- Lock/hysteresis (macro on): 64 valid samples of +10 -> locked=1 the next edge. err=+40 keeps locked; err=+65 drops it next edge. err=-2048 is handled without |err| overflow.
- Valid gaps: err_valid toggling 1/0 with err=+256 -> integ grows only on valid edges; phase_acc still advances every clock.
- Reset mid-run: assert reset_n while locked and integ≠0 -> all outputs take their reset values asynchronously, before the next clock edge.
